// File: rtl/bless_eject_reasm.sv
// Ejection-side packet reassembler for the bufferless router's local port.
// Collects a head control flit plus BEATS payload beats into one packet and
// queues it in a DEPTH-entry FIFO. The router cannot be stalled, so the
// block never backpressures: a packet arriving with the FIFO full is dropped
// and counted.
//
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   eject_ci    : port4 control flit; bit CW-1 marks a head
//   eject_di    : port4 data flit; payload beat k arrives k cycles after head
//   pkt_valid   : FIFO head packet available (registered)
//   pkt_ready   : core accepts the head packet
//   pkt_ctrl    : head packet control word (read from storage)
//   pkt_data    : head packet payload, beat 1 in the low DW bits
//   pkt_count   : committed packets in the FIFO
//   drop_cnt    : packets dropped for FIFO full, saturating
//   proto_err   : sticky, head flit seen while payload was expected
//   err_clr     : synchronous clear of drop_cnt and proto_err
module bless_eject_reasm #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BEATS = 1,
    parameter int unsigned CW    = 28,
    parameter int unsigned DW    = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CW-1:0]               eject_ci,
    input  logic [DW-1:0]               eject_di,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [CW-1:0]               pkt_ctrl,
    output logic [DW*BEATS-1:0]         pkt_data,
    output logic [$clog2(DEPTH):0]      pkt_count,
    output logic [7:0]                  drop_cnt,
    output logic                        proto_err,
    input  logic                        err_clr
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned PW   = DW * BEATS;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t            state, state_n;
    logic [1:0]        beat, beat_n;
    logic              keep, keep_n;
    logic [AW-1:0]     tail, head;
    logic [CNTW-1:0]   count_n;

    logic              head_flit;
    logic              start;
    logic              commit;
    logic              proto_set;
    logic              drop_inc;
    logic              wr_beat;
    logic              pop;

    logic [CW-1:0]     ctrl_mem [DEPTH];
    logic [PW-1:0]     data_mem [DEPTH];

    assign head_flit = eject_ci[CW-1];
    assign pop       = pkt_valid & pkt_ready;

    // Packet assembly FSM: next state and per-cycle actions.
    always_comb begin
        state_n   = state;
        beat_n    = beat;
        keep_n    = keep;
        start     = 1'b0;
        commit    = 1'b0;
        proto_set = 1'b0;
        case (state)
            IDLE: begin
                if (head_flit) begin
                    start = 1'b1;
                end
            end
            PAYLOAD: begin
                if (head_flit) begin
                    // Partial packet is abandoned; the new head is taken as-is.
                    proto_set = 1'b1;
                    start     = 1'b1;
                end else if (beat == 2'(BEATS - 1)) begin
                    commit  = keep;
                    state_n = IDLE;
                end else begin
                    beat_n = beat + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            // Space is judged on the registered count; a same-edge pop earns no credit.
            keep_n  = pkt_count < CNTW'(DEPTH);
            state_n = PAYLOAD;
            beat_n  = 2'd0;
        end
    end

    assign drop_inc = start & ~keep_n;
    assign wr_beat  = (state == PAYLOAD) & ~head_flit & keep;
    assign count_n  = pkt_count + CNTW'(commit) - CNTW'(pop);

    // FSM, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            keep      <= 1'b0;
            tail      <= '0;
            head      <= '0;
            pkt_count <= '0;
            pkt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            keep      <= keep_n;
            if (commit) tail <= tail + AW'(1);
            if (pop)    head <= head + AW'(1);
            pkt_count <= count_n;
            pkt_valid <= (count_n != '0);
        end
    end

    // Packet storage; writes land only in the tail slot of a kept packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (start && keep_n) ctrl_mem[tail] <= eject_ci;
            if (wr_beat) data_mem[tail][int'(beat)*DW +: DW] <= eject_di;
        end
    end

    assign pkt_ctrl = ctrl_mem[head];
    assign pkt_data = data_mem[head];

    // Error reporting; clear wins over a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt  <= 8'd0;
            proto_err <= 1'b0;
        end else if (err_clr) begin
            drop_cnt  <= 8'd0;
            proto_err <= 1'b0;
        end else begin
            if (drop_inc && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
            if (proto_set) proto_err <= 1'b1;
        end
    end

endmodule
